// File: rtl/sel_seq_8_v.sv
// sel_seq_8_v: serialises one accepted byte through an external 8:1 mux.
// The block latches the byte onto o_code, steps the mux select across all
// eight positions, samples the mux output i_f on each step, and reports the
// sampled bits, an end-of-byte pulse and the XOR parity of the sampled bits.
module sel_seq_8_v #(
    parameter int LSB_FIRST = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    input  logic       i_hold,
    output logic [7:0] o_code,
    output logic [2:0] o_sel_code,
    output logic       o_en,
    input  logic       i_f,
    output logic       o_bit,
    output logic       o_bit_valid,
    output logic       o_last,
    output logic       o_done,
    output logic       o_parity
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // First select position and the per-step select move depend on bit order.
    localparam logic [2:0] SEL_START = (LSB_FIRST != 0) ? 3'd0 : 3'd7;

    state_t     state_q, state_d;
    logic [7:0] code_q, code_d;
    logic [2:0] sel_q, sel_d;
    logic       en_q, en_d;
    logic [2:0] cnt_q, cnt_d;
    logic       acc_q, acc_d;
    logic       bit_q, bit_d;
    logic       bit_valid_q, bit_valid_d;
    logic       last_q, last_d;

    // Next-state and datapath: every register holds unless a rule below moves it.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        sel_d       = sel_q;
        en_d        = en_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        bit_d       = bit_q;
        bit_valid_d = 1'b0;
        last_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    code_d  = i_data;
                    sel_d   = SEL_START;
                    en_d    = 1'b1;
                    cnt_d   = 3'd0;
                    acc_d   = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A held step freezes select, count and parity; o_bit keeps its value.
                if (!i_hold) begin
                    bit_d       = i_f;
                    bit_valid_d = 1'b1;
                    acc_d       = acc_q ^ i_f;
                    if (cnt_q == 3'd7) begin
                        // Eighth sample: park the mux and finish the byte.
                        last_d  = 1'b1;
                        en_d    = 1'b0;
                        sel_d   = 3'd0;
                        cnt_d   = 3'd0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        sel_d = (LSB_FIRST != 0) ? (sel_q + 3'd1) : (sel_q - 3'd1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset taking priority over all inputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            code_q      <= 8'd0;
            sel_q       <= 3'd0;
            en_q        <= 1'b0;
            cnt_q       <= 3'd0;
            acc_q       <= 1'b0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            bit_q       <= bit_d;
            bit_valid_q <= bit_valid_d;
            last_q      <= last_d;
        end
    end

    assign o_ready     = (state_q == ST_IDLE) && !i_rst;
    assign o_code      = code_q;
    assign o_sel_code  = sel_q;
    assign o_en        = en_q;
    assign o_bit       = bit_q;
    assign o_bit_valid = bit_valid_q;
    assign o_last      = last_q;
    assign o_done      = (state_q == ST_DONE);
    assign o_parity    = (state_q == ST_DONE) ? acc_q : 1'b0;

endmodule
